local_history_predictor: RTL

- Two-level local branch predictor feeding `lp_prediction` into the tournament choice stage.
- First level: a per-branch local history table (LHT), indexed by PC bits.
- Second level: a pattern history table (PHT) of saturating counters, indexed by the branch's local history.
- Registered prediction output; single-cycle resolve-time update; post-reset table-initialisation sweep.

---
 rtl/local_history_predictor.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/local_history_predictor.sv
// local_history_predictor: two-level local branch predictor.
//   Level 1: local history table (LHT) indexed by pc[PC_IDX_W+1:2].
//   Level 2: pattern history table (PHT) of saturating counters indexed by
//            the branch's local history.
// After reset an init sweep clears every LHT entry and sets every PHT counter
// to weakly-taken. Lookups and updates are ignored until `ready` is high.
// Optional build macro: LP_BYPASS_EN -- a prediction that collides with a
// same-cycle update sees the post-update history/counter instead of the
// pre-update (read-before-write) values.
module local_history_predictor #(
    parameter int PC_IDX_W = 10,
    parameter int LHIST_W  = 10,
    parameter int CTR_W    = 3,
    parameter int PC_W     = 32
) (
    input  logic               clock,
    input  logic               reset,
    output logic               ready,
    input  logic               pred_valid,
    input  logic [PC_W-1:0]    pred_pc,
    output logic               lp_valid,
    output logic               lp_prediction,
    output logic [LHIST_W-1:0] lp_history,
    input  logic               update_valid,
    input  logic [PC_W-1:0]    update_pc,
    input  logic               update_taken
);

    localparam int LHT_DEPTH = 1 << PC_IDX_W;
    localparam int PHT_DEPTH = 1 << LHIST_W;
    localparam int INIT_W    = (PC_IDX_W > LHIST_W) ? PC_IDX_W : LHIST_W;

    localparam logic [CTR_W-1:0] CTR_MAX    = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK_T = CTR_W'(1) << (CTR_W - 1);

    typedef enum logic {
        S_INIT,
        S_READY
    } state_t;

    state_t              state_q, state_d;
    logic [INIT_W-1:0]   init_idx_q, init_idx_d;

    logic [LHIST_W-1:0]  lht_q [LHT_DEPTH];
    logic [CTR_W-1:0]    pht_q [PHT_DEPTH];

    logic                lp_valid_q, lp_valid_d;
    logic                lp_prediction_q, lp_prediction_d;
    logic [LHIST_W-1:0]  lp_history_q, lp_history_d;

    logic [PC_IDX_W-1:0] p_idx, u_idx;
    logic                pred_en, upd_en;
    logic [LHIST_W-1:0]  u_hist, u_hist_new;
    logic [CTR_W-1:0]    u_ctr_new;
    logic [LHIST_W-1:0]  p_hist;
    logic [CTR_W-1:0]    p_ctr;

    // Counter saturation helpers: counters never wrap in either direction.
    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] c);
        return (c == CTR_MAX) ? c : c + CTR_W'(1);
    endfunction

    function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] c);
        return (c == '0) ? c : c - CTR_W'(1);
    endfunction

    function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] c,
                                                  input logic taken);
        return taken ? sat_inc(c) : sat_dec(c);
    endfunction

    assign p_idx   = pred_pc[PC_IDX_W+1:2];
    assign u_idx   = update_pc[PC_IDX_W+1:2];
    assign pred_en = (state_q == S_READY) && pred_valid;
    assign upd_en  = (state_q == S_READY) && update_valid;
    assign ready   = (state_q == S_READY);

    // PC bits outside the LHT index field do not participate in indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[PC_W-1:PC_IDX_W+2], pred_pc[1:0],
                              update_pc[PC_W-1:PC_IDX_W+2], update_pc[1:0]};

    // Resolve-time update values: old history, shifted history, next counter.
    always_comb begin
        u_hist     = lht_q[u_idx];
        u_hist_new = {u_hist[LHIST_W-2:0], update_taken};
        u_ctr_new  = ctr_next(pht_q[u_hist], update_taken);
    end

    // Lookup: history from the LHT, then its counter from the PHT.
    always_comb begin
        p_hist = lht_q[p_idx];
        p_ctr  = pht_q[p_hist];
`ifdef LP_BYPASS_EN
        // Forward the in-flight update so the lookup sees post-update state.
        if (upd_en && (p_idx == u_idx)) begin
            p_hist = u_hist_new;
        end
        if (upd_en && (p_hist == u_hist)) begin
            p_ctr = u_ctr_new;
        end else begin
            p_ctr = pht_q[p_hist];
        end
`endif
    end

    // Next-state logic for the init sweep and the registered prediction.
    always_comb begin
        state_d         = state_q;
        init_idx_d      = init_idx_q;
        lp_valid_d      = pred_en;
        lp_prediction_d = lp_prediction_q;
        lp_history_d    = lp_history_q;
        case (state_q)
            S_INIT: begin
                init_idx_d = init_idx_q + INIT_W'(1);
                if (init_idx_q == '1) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (pred_en) begin
                    lp_prediction_d = p_ctr[CTR_W-1];
                    lp_history_d    = p_hist;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // ---- stage boundary: lookup -> registered prediction outputs ----
    // Control state and output registers, asynchronously reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_INIT;
            init_idx_q      <= '0;
            lp_valid_q      <= 1'b0;
            lp_prediction_q <= 1'b0;
            lp_history_q    <= '0;
        end else begin
            state_q         <= state_d;
            init_idx_q      <= init_idx_d;
            lp_valid_q      <= lp_valid_d;
            lp_prediction_q <= lp_prediction_d;
            lp_history_q    <= lp_history_d;
        end
    end

    // Table writes: init sweep clears entries, READY applies resolved updates.
    always_ff @(posedge clock) begin
        if (state_q == S_INIT) begin
            if (int'(init_idx_q) < LHT_DEPTH) begin
                lht_q[init_idx_q[PC_IDX_W-1:0]] <= '0;
            end
            if (int'(init_idx_q) < PHT_DEPTH) begin
                pht_q[init_idx_q[LHIST_W-1:0]] <= CTR_WEAK_T;
            end
        end else if (upd_en) begin
            lht_q[u_idx]  <= u_hist_new;
            pht_q[u_hist] <= u_ctr_new;
        end
    end

    assign lp_valid      = lp_valid_q;
    assign lp_prediction = lp_prediction_q;
    assign lp_history    = lp_history_q;

endmodule
